fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage that sits directly downstream of the PC register.
- Takes the current PC and PC+4, issues one instruction-memory read at a time over a valid/ready request channel, and captures the response.
- Presents {instr, pc, pc+4, valid} to decode through a registered IF/ID output with a 1-entry skid buffer.
- Drives the PC register's stall input and honours decode stall and branch flush.

Parameters:
- NOP_INSTR, 32'h00000013, instruction driven on if_instr whenever if_valid=0 (addi x0,x0,0).

Ports:
- clock  input  1  clock
- reset  input  1  reset, asynchronous, active-high
- pc  input  32  current fetch address from the PC register
- pc_plus_four  input  32  pc+4 from the PC register
- id_stall  input  1  decode cannot consume the IF/ID entry this cycle
- flush  input  1  branch/jump redirect; wrong-path work is killed
- pc_hold  output  1  to the PC register stall input; 1 = hold PC
- imem_req_valid  output  1  read request valid
- imem_req_ready  input  1  memory accepts request
- imem_addr  output  32  request address (= pc)
- imem_resp_valid  input  1  one-cycle response pulse, no backpressure
- imem_resp_data  input  32  instruction word
- if_valid  output  1  IF/ID entry valid
- if_instr  output  32  instruction, or NOP_INSTR when invalid
- if_pc  output  32  address of if_instr
- if_pc_plus_four  output  32  if_pc+4

Behaviour:
- Reset (async): state=ISSUE, if_valid=0, if_instr=NOP_INSTR, if_pc=0, if_pc_plus_four=0, skid empty, imem_req_valid=0.
- At most one outstanding request.
- req_fire = imem_req_valid & imem_req_ready.
- out_free = !if_valid | !id_stall.
- imem_addr = pc, combinational.
- FSM states: ISSUE, WAIT, DROP.
- ISSUE:
  - imem_req_valid = !flush & skid empty.
  - On req_fire, latch pc/pc_plus_four into req_pc/req_pc4 and go to WAIT.
  - flush suppresses the request, because pc is still the wrong-path value in the flush cycle.
- WAIT:
  - imem_req_valid=0.
  - On imem_resp_valid without flush, deliver {resp_data, req_pc, req_pc4} and go to ISSUE.
  - Delivery goes to the output register if out_free or the skid is empty-and-output-free; otherwise it goes to the skid.
  - flush without resp_valid: go to DROP.
  - flush with resp_valid in the same cycle: discard the response and go to ISSUE.
- DROP:
  - imem_req_valid=0.
  - The next imem_resp_valid is discarded, then go to ISSUE.
  - A further flush while in DROP stays in DROP.
- pc_hold = !req_fire. The PC advances exactly once per accepted request. During flush the PC register overrides pc_hold.
- Output register:
  - Loads when out_free, taking from the skid first, else the arriving response.
  - If out_free and nothing is available, if_valid goes to 0.
  - When !out_free, all if_* outputs hold.
- if_instr = NOP_INSTR whenever if_valid=0.
- Skid: fills only when a response arrives and !out_free; drains into the output register on the next out_free cycle.
- Ordering is preserved: skid contents always precede any later response. No new request is issued while the skid is full.
- flush: next cycle if_valid=0 and the skid is empty. Any pending output with id_stall is discarded.
- Latency: req_fire in cycle N, response in cycle N+k (k≥1), if_valid=1 in cycle N+k+1 when out_free.
- Peak throughput: one instruction per 2 cycles (ISSUE→WAIT with a 1-cycle memory).
- Reset mid-WAIT: the outstanding request is forgotten. The memory must also be reset; a stale response arriving in ISSUE is ignored.
- imem_resp_valid in ISSUE is always ignored.

Test Plan:
1. Reset release with pc=0x01000000, ready=1, 1-cycle memory returning 0x00500093 -> req_fire in cycle 1, pc_hold=0 only in cycle 1, if_valid=1 in cycle 3 with if_instr=0x00500093, if_pc=0x01000000, if_pc_plus_four=0x01000004; 4 sequential fetches give if_pc 0x01000000..0x0100000C in order.
2. imem_req_ready=0 for 3 cycles -> imem_req_valid stays 1, imem_addr stays 0x01000000, pc_hold=1 throughout, no state change.
3. id_stall=1 held while two responses arrive -> the first stays on the if_* outputs, the second goes to the skid, no third request is issued; on release the outputs show both entries on consecutive cycles in order.
4. flush while in WAIT (3-cycle memory latency) -> FSM enters DROP, the late response is discarded, if_valid=0 with if_instr=0x00000013, the next request uses the redirected pc (e.g. 0x01000040).
5. flush in the same cycle as imem_resp_valid with id_stall=1 and the skid full -> next cycle if_valid=0, skid empty, FSM in ISSUE; no wrong-path instruction ever appears with if_valid=1.
6. Assert reset while in WAIT with if_valid=1 -> immediately if_valid=0, if_pc=0, imem_req_valid=0; a response pulse arriving after reset is ignored.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: single-outstanding imem reads, registered IF/ID
// output with a one-entry skid buffer, decode stall and branch flush.
module fetch_stage #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] pc,
    input  logic [31:0] pc_plus_four,
    input  logic        id_stall,
    input  logic        flush,
    output logic        pc_hold,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_resp_valid,
    input  logic [31:0] imem_resp_data,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic [31:0] if_pc_plus_four
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        S_ISSUE = 2'd0,
        S_WAIT  = 2'd1,
        S_DROP  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [XLEN-1:0]   req_pc_q, req_pc_d, req_pc4_q, req_pc4_d;
    logic              skid_valid_q, skid_valid_d;
    logic [XLEN-1:0]   skid_instr_q, skid_instr_d, skid_pc_q, skid_pc_d, skid_pc4_q, skid_pc4_d;
    logic              out_valid_q, out_valid_d;
    logic [XLEN-1:0]   out_instr_q, out_instr_d, out_pc_q, out_pc_d, out_pc4_q, out_pc4_d;

    logic req_fire;
    logic out_free;
    logic deliver;

    // The request is held back during flush since pc is still the wrong-path value.
    assign imem_req_valid = !reset && (state_q == S_ISSUE) && !flush && !skid_valid_q;
    assign imem_addr      = pc;
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_hold        = !req_fire;
    assign out_free       = !out_valid_q || !id_stall;
    assign deliver        = (state_q == S_WAIT) && imem_resp_valid && !flush;

    assign if_valid        = out_valid_q;
    assign if_instr        = out_instr_q;
    assign if_pc           = out_pc_q;
    assign if_pc_plus_four = out_pc4_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_ISSUE;
        end else begin
            state_q <= state_d;
        end
    end

    // DROP always leaves on the next response, flushed or not: nothing else is in flight.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_ISSUE: if (req_fire) state_d = S_WAIT;
            S_WAIT: begin
                if (flush)                state_d = imem_resp_valid ? S_ISSUE : S_DROP;
                else if (imem_resp_valid) state_d = S_ISSUE;
            end
            S_DROP:  if (imem_resp_valid) state_d = S_ISSUE;
            default: state_d = S_ISSUE;
        endcase
    end

    // Output register and skid: skid drains first so program order is kept.
    always_comb begin
        req_pc_d     = req_pc_q;
        req_pc4_d    = req_pc4_q;
        skid_valid_d = skid_valid_q;
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_pc4_d   = skid_pc4_q;
        out_valid_d  = out_valid_q;
        out_instr_d  = out_instr_q;
        out_pc_d     = out_pc_q;
        out_pc4_d    = out_pc4_q;

        if (req_fire) begin
            req_pc_d  = pc;
            req_pc4_d = pc_plus_four;
        end

        if (flush) begin
            out_valid_d  = 1'b0;
            out_instr_d  = NOP_INSTR;
            skid_valid_d = 1'b0;
        end else if (out_free) begin
            if (skid_valid_q) begin
                out_valid_d  = 1'b1;
                out_instr_d  = skid_instr_q;
                out_pc_d     = skid_pc_q;
                out_pc4_d    = skid_pc4_q;
                skid_valid_d = deliver;
                if (deliver) begin
                    skid_instr_d = imem_resp_data;
                    skid_pc_d    = req_pc_q;
                    skid_pc4_d   = req_pc4_q;
                end
            end else if (deliver) begin
                out_valid_d = 1'b1;
                out_instr_d = imem_resp_data;
                out_pc_d    = req_pc_q;
                out_pc4_d   = req_pc4_q;
            end else begin
                out_valid_d = 1'b0;
                out_instr_d = NOP_INSTR;
            end
        end else if (deliver) begin
            skid_valid_d = 1'b1;
            skid_instr_d = imem_resp_data;
            skid_pc_d    = req_pc_q;
            skid_pc4_d   = req_pc4_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            req_pc_q     <= '0;
            req_pc4_q    <= '0;
            skid_valid_q <= 1'b0;
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_pc4_q   <= '0;
            out_valid_q  <= 1'b0;
            out_instr_q  <= NOP_INSTR;
            out_pc_q     <= '0;
            out_pc4_q    <= '0;
        end else begin
            req_pc_q     <= req_pc_d;
            req_pc4_q    <= req_pc4_d;
            skid_valid_q <= skid_valid_d;
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_pc4_q   <= skid_pc4_d;
            out_valid_q  <= out_valid_d;
            out_instr_q  <= out_instr_d;
            out_pc_q     <= out_pc_d;
            out_pc4_q    <= out_pc4_d;
        end
    end

endmodule
